// File: rtl/psum_mem_arbiter_pkg.sv
// Shared types and helpers for the partial-sum memory arbiter slice.
package psum_mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 20;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/psum_mem_arbiter_rr.sv
// Pure 2-way round-robin grant: on a tie the port that did not win last time wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // One-hot (or zero) grant from the requests and the previous winner
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last_grant)) gnt[0] = 1'b1;
        else if (req[1])                       gnt[1] = 1'b1;
    end

endmodule

// File: rtl/psum_mem_arbiter.sv
// Shares the single-port psum SRAM between the conv controller (port 0) and
// the host/drain side (port 1): round-robin with optional bounded burst lock,
// 1-cycle read responses steered back to the issuing port, and a saturating
// count of contended cycles.
module psum_mem_arbiter
    import psum_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              arst_n_in,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r0_lock,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic              r1_lock,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       conflict_cnt
);

    localparam int LCW = $clog2(MAX_LOCK + 1);

    arb_state_t     state_q, state_d;
    logic           last_grant_q;
    logic [LCW-1:0] lock_cnt_q;
    logic           rv0_q, rv1_q;
    logic [31:0]    conflict_q;
    logic [1:0]     rr_gnt, gnt;
    logic           xfer, xfer_port, xfer_lock, lock_last;

    rr_arbiter2 u_rr (
        .req        ({r1_valid, r0_valid}),
        .last_grant (last_grant_q),
        .gnt        (rr_gnt)
    );

    assign xfer      = |gnt;
    assign xfer_port = gnt[1];
    assign xfer_lock = gnt[1] ? r1_lock : r0_lock;
    assign lock_last = (lock_cnt_q == LCW'(MAX_LOCK - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!arst_n_in) state_q <= ARB;
        else            state_q <= state_d;
    end

    // Next state: enter a lock on a locked transfer, leave on unlock or when the burst bound is hit
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:          if (xfer && xfer_lock && (MAX_LOCK > 1))
                              state_d = xfer_port ? LOCK1 : LOCK0;
            LOCK0, LOCK1: if (xfer && (!xfer_lock || lock_last))
                              state_d = ARB;
            default:      state_d = ARB;
        endcase
    end

    // Grants: round-robin in ARB, only the owner while locked; nothing moves while in reset
    always_comb begin
        gnt = 2'b00;
        if (arst_n_in) begin
            case (state_q)
                ARB:     gnt = rr_gnt;
                LOCK0:   gnt = {1'b0, r0_valid};
                LOCK1:   gnt = {r1_valid, 1'b0};
                default: gnt = 2'b00;
            endcase
        end
    end

    assign r0_ready = gnt[0];
    assign r1_ready = gnt[1];

    // Memory drive follows the granted port in the same cycle
    always_comb begin
        mem_en    = xfer;
        mem_we    = xfer && (xfer_port ? r1_we : r0_we);
        mem_addr  = xfer_port ? r1_addr  : r0_addr;
        mem_wdata = xfer_port ? r1_wdata : r0_wdata;
    end

    // Burst length within the current lock: 1 after the entering transfer
    always_ff @(posedge clk) begin
        if (!arst_n_in)            lock_cnt_q <= '0;
        else if (xfer) begin
            if (state_d == ARB)    lock_cnt_q <= '0;
            else if (state_q == ARB) lock_cnt_q <= LCW'(1);
            else                   lock_cnt_q <= lock_cnt_q + LCW'(1);
        end
    end

    // Last winner; reset to 1 so port 0 takes the first tie
    always_ff @(posedge clk) begin
        if (!arst_n_in) last_grant_q <= 1'b1;
        else if (xfer)  last_grant_q <= xfer_port;
    end

    // Read response flags, one cycle behind the accepted read
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
        end else begin
            rv0_q <= gnt[0] && !r0_we;
            rv1_q <= gnt[1] && !r1_we;
        end
    end

    // A reset landing on the response cycle kills that response too
    assign r0_rvalid = rv0_q && arst_n_in;
    assign r1_rvalid = rv1_q && arst_n_in;
    assign r0_rdata  = mem_rdata;
    assign r1_rdata  = mem_rdata;

    // Contended cycles, counted regardless of lock state
    always_ff @(posedge clk) begin
        if (!arst_n_in)                conflict_q <= '0;
        else if (r0_valid && r1_valid) conflict_q <= sat_inc32(conflict_q);
    end

    assign conflict_cnt = conflict_q;

endmodule
